bcd_display_scanner: RTL
========================

# bcd_display_scanner

Downstream consumer of the binary-to-BCD converter. Latches a multi-digit packed BCD value on a load strobe and drives a time-multiplexed common-anode 7-segment display, one digit per scan slot. Provides leading-zero blanking, a dash glyph for invalid nibbles, a sticky invalid flag and a per-frame pulse. The 5-bit converter output {t,u[3:0]} connects as bcd_in = {3'b000, t, u}.

## Interface
- NUM_DIGITS, 2, number of BCD digits / anodes (>=1)
- PRESCALE, 4, clock cycles per digit slot (>=1)
- SEG_ACTIVE_LOW, 1, 1: seg and an are active-low; 0: active-high
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous reset, active-high
- bcd_in  in  4*NUM_DIGITS  packed BCD, digit 0 in [3:0]
- load  in  1  capture bcd_in into display register this edge
- blank_lz  in  1  enable leading-zero blanking
- seg  out  7  {g,f,e,d,c,b,a}, registered
- an  out  NUM_DIGITS  digit enables, one-hot (polarity per SEG_ACTIVE_LOW), registered
- frame_done  out  1  one-cycle pulse at end of each full scan, registered
- invalid  out  1  sticky: some loaded nibble was >9

## Operation
- Display register disp: cleared by rst; on load=1, disp <= bcd_in. rst beats load.
- invalid: cleared by rst only; set on any load whose bcd_in has a nibble in 10..15.
- Counters: pre_cnt 0..PRESCALE-1, idx 0..NUM_DIGITS-1. pre_cnt increments each cycle; at PRESCALE-1 it wraps to 0 and idx advances, wrapping NUM_DIGITS-1 -> 0. load does not disturb counters.
- Glyphs (active-high form): 0=0x3F 1=0x06 2=0x5B 3=0x4F 4=0x66 5=0x6D 6=0x7D 7=0x07 8=0x7F 9=0x6F; 10..15 = dash 0x40. Inverted on the pins when SEG_ACTIVE_LOW=1.
- Leading-zero blanking: digit i>0 is blanked when blank_lz=1, disp[i]==0 and every digit above i is 0. A blanked slot drives all segments off and all anodes off. Digit 0 is never blanked.
- Each edge (not rst): an <= enable for idx; seg <= glyph of disp[idx] (or off if blanked), using pre-edge idx/disp.
- frame_done <= (idx==NUM_DIGITS-1 && pre_cnt==PRESCALE-1).

## Timing
- Reset values: seg all segments off (7'h7F when active-low), an all off, frame_done 0, invalid 0, disp 0, pre_cnt 0, idx 0.
- First edge after rst deasserts: an selects digit 0, seg shows glyph of 0 (disp cleared).
- Outputs lag counters/disp by one cycle. Load at edge E -> new glyph visible from edge E+1 if that digit's slot is current.
- Each digit is driven for exactly PRESCALE cycles; full frame = NUM_DIGITS*PRESCALE cycles; frame_done period equals frame length, high one cycle, coincident with the first cycle of digit 0's next slot.
- PRESCALE=1: idx advances every cycle. NUM_DIGITS=1: idx stays 0, frame_done every PRESCALE cycles.
- rst mid-frame: all state returns to reset values at that edge; scan restarts at digit 0.

## Structure
- Package bcd_display_pkg: glyph constants (GLYPH_0..GLYPH_9, GLYPH_DASH, GLYPH_OFF), BCD_W=4, SEG_W=7.
- Sub-module bcd_to_seg7: combinational 4-bit to 7-bit active-high decoder, one instance on the idx-muxed nibble; polarity inversion and blanking in the top.

## Test plan
- NUM_DIGITS=2, PRESCALE=4, active-low. rst held 3 cycles -> seg=7'h7F, an=2'b11, frame_done=0, invalid=0.
- load bcd_in=8'h15 -> an=2'b10, seg=7'h12 for 4 cycles, then an=2'b01, seg=7'h79 for 4 cycles; frame_done pulses every 8 cycles.
- blank_lz=1, load 8'h07 -> digit-1 slot an=2'b11, seg=7'h7F; digit 0 seg=7'h78. blank_lz=0 -> digit 1 shows seg=7'h40.
- load 8'h0A -> digit 0 seg=7'h3F (dash), invalid=1; then load 8'h09 -> invalid stays 1 until rst.
- load 8'h23 in cycle 2 of digit-0 slot -> digit 0 seg=7'h30 from next cycle; slot still ends on schedule.
- rst and load both high mid-frame -> disp=0, outputs at reset values, scan restarts at digit 0.

Source files
------------

// File: rtl/bcd_display_pkg.sv
// bcd_display_pkg: seven-segment glyph constants and BCD helpers for the display scanner
package bcd_display_pkg;
  localparam int BCD_W = 4;
  localparam int SEG_W = 7;
  localparam logic [SEG_W-1:0] GLYPH_0    = 7'h3F;
  localparam logic [SEG_W-1:0] GLYPH_1    = 7'h06;
  localparam logic [SEG_W-1:0] GLYPH_2    = 7'h5B;
  localparam logic [SEG_W-1:0] GLYPH_3    = 7'h4F;
  localparam logic [SEG_W-1:0] GLYPH_4    = 7'h66;
  localparam logic [SEG_W-1:0] GLYPH_5    = 7'h6D;
  localparam logic [SEG_W-1:0] GLYPH_6    = 7'h7D;
  localparam logic [SEG_W-1:0] GLYPH_7    = 7'h07;
  localparam logic [SEG_W-1:0] GLYPH_8    = 7'h7F;
  localparam logic [SEG_W-1:0] GLYPH_9    = 7'h6F;
  localparam logic [SEG_W-1:0] GLYPH_DASH = 7'h40;
  localparam logic [SEG_W-1:0] GLYPH_OFF  = 7'h00;
  function automatic logic is_bcd(input logic [BCD_W-1:0] n);
    return n <= 4'd9;
  endfunction
endpackage

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7: combinational BCD nibble to active-high {g..a} glyph, dash for 10..15
module bcd_to_seg7 import bcd_display_pkg::*; (
  input  logic [BCD_W-1:0] bcd,
  output logic [SEG_W-1:0] seg
);
  always_comb begin
    case (bcd)
      4'd0:    seg = GLYPH_0;
      4'd1:    seg = GLYPH_1;
      4'd2:    seg = GLYPH_2;
      4'd3:    seg = GLYPH_3;
      4'd4:    seg = GLYPH_4;
      4'd5:    seg = GLYPH_5;
      4'd6:    seg = GLYPH_6;
      4'd7:    seg = GLYPH_7;
      4'd8:    seg = GLYPH_8;
      4'd9:    seg = GLYPH_9;
      default: seg = GLYPH_DASH;
    endcase
  end
endmodule

// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner: latches packed BCD and time-multiplexes it onto a 7-segment display
module bcd_display_scanner import bcd_display_pkg::*; #(
  parameter int NUM_DIGITS     = 2,
  parameter int PRESCALE       = 4,
  parameter bit SEG_ACTIVE_LOW = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [BCD_W*NUM_DIGITS-1:0] bcd_in,
  input  logic                        load,
  input  logic                        blank_lz,
  output logic [SEG_W-1:0]            seg,
  output logic [NUM_DIGITS-1:0]       an,
  output logic                        frame_done,
  output logic                        invalid
);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [SEG_W-1:0]      SEG_MASK = {SEG_W{SEG_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] AN_MASK  = {NUM_DIGITS{SEG_ACTIVE_LOW}};
  logic [BCD_W*NUM_DIGITS-1:0] disp;
  logic [PW-1:0]               pre_cnt;
  logic [IW-1:0]               idx;
  logic [BCD_W-1:0]            nib;
  logic [SEG_W-1:0]            glyph;
  logic [NUM_DIGITS-1:0]       lz;
  logic [NUM_DIGITS-1:0]       an_sel;
  logic                        bad, zero_run, blanked, pre_wrap, idx_last;
  // lz[i] marks digit i as part of the all-zero run down from the top digit
  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) bad = bad | !is_bcd(bcd_in[i*BCD_W +: BCD_W]);
    lz = '0;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_run = zero_run & (disp[i*BCD_W +: BCD_W] == '0);
      lz[i] = zero_run;
    end
  end
  assign nib      = disp[idx*BCD_W +: BCD_W];
  assign pre_wrap = pre_cnt == PW'(PRESCALE - 1);
  assign idx_last = idx == IW'(NUM_DIGITS - 1);
  assign blanked  = blank_lz && lz[idx];
  assign an_sel   = NUM_DIGITS'(1) << idx;
  bcd_to_seg7 u_dec (.bcd(nib), .seg(glyph));
  always_ff @(posedge clk) begin
    if (rst) begin
      disp       <= '0;
      invalid    <= 1'b0;
      pre_cnt    <= '0;
      idx        <= '0;
      seg        <= GLYPH_OFF ^ SEG_MASK;
      an         <= AN_MASK;
      frame_done <= 1'b0;
    end else begin
      if (load) disp <= bcd_in;
      if (load && bad) invalid <= 1'b1;
      pre_cnt    <= pre_wrap ? '0 : pre_cnt + 1'b1;
      if (pre_wrap) idx <= idx_last ? '0 : idx + 1'b1;
      an         <= blanked ? AN_MASK : an_sel ^ AN_MASK;
      seg        <= (blanked ? GLYPH_OFF : glyph) ^ SEG_MASK;
      frame_done <= idx_last && pre_wrap;
    end
  end
endmodule
